// File: rtl/ctrl_plane_arbiter.sv
// Control-plane arbiter: collects TDM upstream path requests into a FIFO and broadcasts GRANT/RELEASE words.
// Optional lease timeout is compiled in when ARB_TIMEOUT_EN is defined.
module ctrl_plane_arbiter #(
    parameter int NODES          = 16,
    parameter int SLOT_CYCLES    = 4,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      max_node,
    input  logic [31:0]      ctrl_up_packet,
    output logic [15:0]      slot_node_id,
    output logic [31:0]      ctrl_down_packet,
    output logic [NODES-1:0] node_busy,
    output logic [15:0]      drop_count,
    output logic [1:0]       fsm_state
);
    localparam int NW = (NODES > 1) ? $clog2(NODES) : 1;
    localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [3:0] PT_REQ   = 4'd1;
    localparam logic [3:0] PT_GRANT = 4'd2;
    localparam logic [3:0] PT_REL   = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    state_t state, state_next;

    // Handshake: the upstream word is taken only on the last cycle of a slot;
    // ctrl_down_packet carries one event for exactly one cycle and is 0 otherwise.
    logic [15:0]   eff_max;
    logic [SW-1:0] slot_cnt;
    logic          slot_end;

    always_comb begin
        eff_max = max_node;
        if (max_node == 16'd0 || {16'd0, max_node} > 32'(NODES)) eff_max = 16'(NODES);
    end

    assign slot_end = (slot_cnt == SW'(SLOT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_cnt     <= '0;
            slot_node_id <= 16'd0;
        end else if (slot_end) begin
            slot_cnt     <= '0;
            slot_node_id <= (slot_node_id + 16'd1 >= eff_max) ? 16'd0 : slot_node_id + 16'd1;
        end else begin
            slot_cnt <= slot_cnt + SW'(1);
        end
    end

    logic [3:0]    up_type;
    logic [7:0]    up_src, up_dst;
    logic [11:0]   up_len;
    logic [NW-1:0] src_idx;
    logic          src_is_slot, req_seen, req_ok, rel_fire;

    assign up_type     = ctrl_up_packet[31:28];
    assign up_src      = ctrl_up_packet[27:20];
    assign up_dst      = ctrl_up_packet[19:12];
    assign up_len      = ctrl_up_packet[11:0];
    assign src_idx     = up_src[NW-1:0];
    assign src_is_slot = slot_end && ({8'd0, up_src} == slot_node_id);
    assign req_seen    = slot_end && (up_type == PT_REQ);
    assign req_ok      = req_seen && src_is_slot && ({8'd0, up_dst} < eff_max)
                         && (up_dst != up_src) && (up_len != 12'd0);
    assign rel_fire    = src_is_slot && (up_type == PT_REL) && node_busy[src_idx];

    logic [27:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic          fifo_full, push, pop, drop;
    logic [27:0]   head;
    logic [NW-1:0] hs_idx, hd_idx;

    assign fifo_full = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
    assign push      = req_ok && (!fifo_full || pop);
    assign drop      = req_seen && !push;
    assign head      = fifo_mem[rd_ptr];
    assign hs_idx    = head[20+NW-1:20];
    assign hd_idx    = head[12+NW-1:12];

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {up_src, up_dst, up_len};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      fifo_cnt <= fifo_cnt + (AW+1)'(1);
            else if (pop && !push) fifo_cnt <= fifo_cnt - (AW+1)'(1);
        end
    end

    logic [NW-1:0]    partner [NODES];
    logic [NODES-1:0] rel_mask, busy_avail, grant_mask, to_mask;
    logic [NW-1:0]    to_idx;
    logic             to_fire, head_free;

    always_comb begin
        rel_mask = '0;
        if (rel_fire) rel_mask = (NODES'(1) << src_idx) | (NODES'(1) << partner[src_idx]);
    end

    // The head is judged against the lease table as it stands after this cycle's release.
    assign busy_avail = node_busy & ~rel_mask;
    assign head_free  = !busy_avail[hs_idx] && !busy_avail[hd_idx];
    assign grant_mask = pop ? ((NODES'(1) << hs_idx) | (NODES'(1) << hd_idx)) : '0;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] LEASE_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0]    lease_cnt [NODES];
    logic [NODES-1:0] lease_on;
    logic             expired;

    // Lease counters live on the requesting node; the lowest expired index wins.
    always_comb begin
        expired = 1'b0;
        to_idx  = '0;
        for (int n = NODES - 1; n >= 0; n--) begin
            if (lease_on[n] && lease_cnt[n] == LEASE_LAST) begin
                expired = 1'b1;
                to_idx  = NW'(n);
            end
        end
        to_fire = expired && !rel_fire;
        to_mask = '0;
        if (to_fire) to_mask = (NODES'(1) << to_idx) | (NODES'(1) << partner[to_idx]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lease_on <= '0;
            for (int n = 0; n < NODES; n++) lease_cnt[n] <= '0;
        end else begin
            for (int n = 0; n < NODES; n++) begin
                if (pop && hs_idx == NW'(n)) begin
                    lease_on[n]  <= 1'b1;
                    lease_cnt[n] <= '0;
                end else if (rel_mask[n] || to_mask[n]) begin
                    lease_on[n] <= 1'b0;
                end else if (lease_on[n] && lease_cnt[n] != LEASE_LAST) begin
                    lease_cnt[n] <= lease_cnt[n] + TW'(1);
                end
            end
        end
    end
`else
    assign to_fire = 1'b0;
    assign to_idx  = '0;
    assign to_mask = '0;
    // Keeps the lease limit referenced while the timer is compiled out.
    if (TIMEOUT_CYCLES > 0) begin : g_no_lease_timer
    end
`endif

    logic        blocked, grant_emit, grant_hold, hold_next;
    logic [31:0] grant_word, down_next;

    assign blocked = rel_fire || to_fire;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        grant_emit = 1'b0;
        hold_next  = grant_hold;
        case (state)
            ST_IDLE: begin
                if (fifo_cnt != '0 || req_ok) state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (head_free) begin
                    pop        = 1'b1;
                    grant_emit = !blocked;
                    hold_next  = blocked;
                    state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!grant_hold) begin
                    state_next = ST_IDLE;
                end else if (!blocked) begin
                    grant_emit = 1'b1;
                    hold_next  = 1'b0;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // One broadcast per cycle: upstream RELEASE, then timeout, then GRANT.
    always_comb begin
        down_next = 32'd0;
        if (rel_fire)
            down_next = {PT_REL, up_src, 8'(partner[src_idx]), 12'h000};
        else if (to_fire)
            down_next = {PT_REL, 8'(to_idx), 8'(partner[to_idx]), 12'hFFF};
        else if (grant_emit)
            down_next = (state == ST_CHECK) ? {PT_GRANT, head} : grant_word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= ST_IDLE;
            grant_hold       <= 1'b0;
            grant_word       <= 32'd0;
            ctrl_down_packet <= 32'd0;
            node_busy        <= '0;
            drop_count       <= 16'd0;
            for (int n = 0; n < NODES; n++) partner[n] <= '0;
        end else begin
            state            <= state_next;
            grant_hold       <= hold_next;
            ctrl_down_packet <= down_next;
            node_busy        <= (node_busy & ~rel_mask & ~to_mask) | grant_mask;
            if (pop) begin
                grant_word      <= {PT_GRANT, head};
                partner[hs_idx] <= hd_idx;
                partner[hd_idx] <= hs_idx;
            end
            if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

    assign fsm_state = state;

endmodule

// File: doc/ctrl_plane_arbiter.md
Name: ctrl_plane_arbiter

Overview:
Central control-plane arbiter at the network end of the photonic interconnect. It owns the node-to-arbiter control channel, which is time-division multiplexed across nodes. It collects data-plane path requests from each Computer node's control_tx_packet, queues them, and broadcasts GRANT/RELEASE packets that every node receives on control_rx_packet. It guarantees each node is in at most one data-plane transfer at a time, as either source or destination.

Parameters:
NODES, 16, number of node slots supported; busy/partner tables are sized by this.
SLOT_CYCLES, 4, clock cycles per TDM upstream slot (>=2).
FIFO_DEPTH, 8, request queue entries (power of 2).
TIMEOUT_CYCLES, 1024, lease limit; used only with ARB_TIMEOUT_EN.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
max_node  in  16  active node count; values of 0 or >NODES are treated as NODES
ctrl_up_packet  in  32  upstream control word from the node owning the current slot
slot_node_id  out  16  node id owning the current upstream slot
ctrl_down_packet  out  32  broadcast control word to all nodes
node_busy  out  NODES  bit n set = node n leased
drop_count  out  16  saturating count of dropped requests (malformed or FIFO full)

Behaviour:
- Packet format: [31:28] type (0 IDLE, 1 REQ, 2 GRANT, 3 RELEASE); [27:20] src; [19:12] dst; [11:0] length in words.
- Reset (rst=0, async): slot_node_id=0, slot cycle counter=0, FIFO empty, node_busy=0, partner table=0, drop_count=0, ctrl_down_packet=0, FSM=IDLE.
- TDM: slot cycle counter runs 0..SLOT_CYCLES-1. On wrap, slot_node_id increments, wrapping from eff_max-1 to 0, where eff_max is the clamped max_node. ctrl_up_packet is sampled only on cycle SLOT_CYCLES-1 of each slot.
- If max_node changes so that slot_node_id >= eff_max, the next slot wrap goes to 0.
- Sampled REQ is valid if: src==slot_node_id, dst<eff_max, dst!=src, length!=0.
  - Valid and FIFO not full: push {src,dst,length}.
  - Otherwise: drop and increment drop_count (saturates at 0xFFFF).
  - REQ from an already-busy src is still queued.
- Sampled RELEASE is valid if src==slot_node_id and busy[src]=1. It clears busy[src] and busy[partner[src]] and broadcasts RELEASE {src, partner}. Invalid RELEASE is ignored with no count. IDLE/GRANT upstream words are ignored.
- Grant FSM:
  - IDLE: when FIFO is non-empty, go to CHECK.
  - CHECK (1 cycle): evaluate head against busy state after this cycle's release.
    - Both src and dst free: pop, set both busy, partner[src]=dst, partner[dst]=src, go to GRANT.
    - Otherwise: stay in CHECK. Head-of-line blocking; retry every cycle.
  - GRANT (1 cycle): ctrl_down_packet = {2, src, dst, length}, then return to IDLE.
- Grant latency: the GRANT word appears 2 cycles after the sample when the FIFO is empty and both nodes are free.
- ctrl_down_packet is valid for exactly one cycle per event and is 0 otherwise.
- Same-cycle RELEASE and GRANT: RELEASE is broadcast that cycle and GRANT is held one cycle. No event is ever lost.
- Same-cycle push and pop are allowed when the FIFO is full; a full FIFO with a simultaneous pop accepts the push.
- Mid-operation reset clears all leases immediately. No RELEASE packets are broadcast.

Optional Feature:
ARB_TIMEOUT_EN
- Defined: each leased pair has a lease counter that starts at grant. At TIMEOUT_CYCLES without a RELEASE, the arbiter clears both busy bits and broadcasts RELEASE {src, dst} with length=0xFFF to flag the timeout. This uses the same one-event-per-cycle arbitration, with priority order: upstream RELEASE > timeout > GRANT.
- Undefined: leases persist until an explicit RELEASE. No counters are synthesised.

Test Plan:
- Basic grant: eff_max=4; node 1 slot sends REQ src1 dst3 len16 -> GRANT 0x2_01_03_010 two cycles after the sample; node_busy=0b1010.
- Release: node 1 slot sends RELEASE src1 -> ctrl_down_packet=0x3_01_03_000 one cycle later; node_busy=0.
- Contention: node0 holds a lease with node2. Node1 REQ dst2 is queued and blocked. Node0 then sends RELEASE -> RELEASE broadcast, then GRANT 1->2 on the following cycle.
- Malformed and overflow:
  - REQ with src!=slot, dst==src, or dst>=eff_max -> drop_count increments; no GRANT.
  - 9 valid REQs to busy destinations with FIFO_DEPTH=8 -> drop_count=1.
- TDM wrap: max_node=3 -> slot_node_id sequence 0,1,2,0 every SLOT_CYCLES cycles; max_node=0 -> sequence wraps at 15.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=32): grant 0->1 with no release -> RELEASE 0x3_00_01_FFF 32 cycles after the GRANT; node_busy=0. Asserting rst mid-lease clears node_busy asynchronously.
